// File: rtl/dual_input_debouncer.sv
// Two-channel synchronizer + debouncer: each raw input passes a 2-flop synchronizer and
// a stability filter, producing a clean level plus registered rise/fall pulses.

module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // cnt counts synced cycles that disagree with level; it is always 0 in STABLE, so the
  // same acceptance compare works from either state (including DEBOUNCE_CYCLES == 1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE;
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE: begin
          if (s2 != level) begin
            if (cnt == LAST) begin
              level <= s2;
              rise  <= s2;
              fall  <= ~s2;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= PENDING;
            end
          end
        end
        PENDING: begin
          if (s2 == level) begin
            cnt   <= '0;
            state <= STABLE;
          end else if (cnt == LAST) begin
            level <= s2;
            rise  <= s2;
            fall  <= ~s2;
            cnt   <= '0;
            state <= STABLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= STABLE;
        end
      endcase
    end
  end

endmodule

module dual_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic CLK,
  input  logic RST,
  input  logic RAW_A,
  input  logic RAW_B,
  output logic A,
  output logic B,
  output logic A_RISE,
  output logic A_FALL,
  output logic B_RISE,
  output logic B_FALL
);

  // Channels share only clock and reset; no state crosses between them.
  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk  (CLK),
    .rst  (RST),
    .raw  (RAW_A),
    .level(A),
    .rise (A_RISE),
    .fall (A_FALL)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk  (CLK),
    .rst  (RST),
    .raw  (RAW_B),
    .level(B),
    .rise (B_RISE),
    .fall (B_FALL)
  );

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Directed bench for dual_input_debouncer: a DEBOUNCE_CYCLES=4 instance and a =1 instance,
// with per-cycle expected output vectors queued as stimulus is driven.

module tb_dual_input_debouncer;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst;
  logic raw_a, raw_b, raw_a1, raw_b1;
  logic a, b, a_rise, a_fall, b_rise, b_fall;
  logic a1, b1, a1_rise, a1_fall, b1_rise, b1_fall;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dual_input_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(5)) dut4 (
    .CLK(clk), .RST(rst), .RAW_A(raw_a), .RAW_B(raw_b),
    .A(a), .B(b), .A_RISE(a_rise), .A_FALL(a_fall), .B_RISE(b_rise), .B_FALL(b_fall)
  );

  dual_input_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (
    .CLK(clk), .RST(rst), .RAW_A(raw_a1), .RAW_B(raw_b1),
    .A(a1), .B(b1), .A_RISE(a1_rise), .A_FALL(a1_fall), .B_RISE(b1_rise), .B_FALL(b1_fall)
  );

  // Observed vector: [11:6] DC=4 instance, [5:0] DC=1 instance; each {x, x_rise, x_fall} for A then B.
  function automatic logic [W-1:0] observed();
    return {a, a_rise, a_fall, b, b_rise, b_fall,
            a1, a1_rise, a1_fall, b1, b1_rise, b1_fall};
  endfunction

  function automatic logic [5:0] ch(input logic xa, input logic xar, input logic xaf,
                                    input logic xb, input logic xbr, input logic xbf);
    return {xa, xar, xaf, xb, xbr, xbf};
  endfunction

  // ---------------- driver / scoreboard tasks ----------------
  task automatic check(input string tag, input logic [W-1:0] expv);
    logic [W-1:0] obs;
    obs = observed();
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, expv);
    end
  endtask

  // Queue the expected outputs for the next edge, clock it, then pop and compare 1ns later.
  task automatic tick(input string tag, input logic [5:0] e4, input logic [5:0] e1);
    logic [W-1:0] expv;
    exp_q.push_back({e4, e1});
    @(posedge clk);
    #1;
    expv = exp_q.pop_front();
    check(tag, expv);
  endtask

  task automatic ticks(input string tag, input int n, input logic [5:0] e4, input logic [5:0] e1);
    for (int i = 0; i < n; i++) tick(tag, e4, e1);
  endtask

  localparam logic [5:0] Z = 6'b0;

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; raw_a = 1'b0; raw_b = 1'b0; raw_a1 = 1'b0; raw_b1 = 1'b0;
    ticks("reset", 3, Z, Z);
    rst = 1'b0;
    ticks("idle", 3, Z, Z);

    // 3-cycle glitch on A must be rejected, then a 1-cycle pulse proves the count cleared
    raw_a = 1'b1;
    ticks("glitch3", 3, Z, Z);
    raw_a = 1'b0;
    ticks("glitch3_after", 8, Z, Z);
    raw_a = 1'b1;
    tick("glitch1", Z, Z);
    raw_a = 1'b0;
    ticks("glitch1_after", 8, Z, Z);

    // A rises on the 6th edge with a single A_RISE; B side untouched
    raw_a = 1'b1;
    ticks("a_rise_wait", 5, Z, Z);
    tick("a_rise", ch(1, 1, 0, 0, 0, 0), Z);
    ticks("a_high", 3, ch(1, 0, 0, 0, 0, 0), Z);
    raw_a = 1'b0;
    ticks("a_fall_wait", 5, ch(1, 0, 0, 0, 0, 0), Z);
    tick("a_fall", ch(0, 0, 1, 0, 0, 0), Z);
    ticks("a_low", 2, Z, Z);

    // Simultaneous change on both channels
    raw_a = 1'b1; raw_b = 1'b1;
    ticks("ab_rise_wait", 5, Z, Z);
    tick("ab_rise", ch(1, 1, 0, 1, 1, 0), Z);
    ticks("ab_high", 2, ch(1, 0, 0, 1, 0, 0), Z);
    raw_a = 1'b0; raw_b = 1'b0;
    ticks("ab_fall_wait", 5, ch(1, 0, 0, 1, 0, 0), Z);
    tick("ab_fall", ch(0, 0, 1, 0, 0, 1), Z);
    ticks("ab_low", 2, Z, Z);

    // B toggles every 2 cycles for 20 cycles, then holds high
    for (int i = 0; i < 10; i++) begin
      raw_b = ~raw_b;
      ticks("b_chatter", 2, Z, Z);
    end
    raw_b = 1'b1;
    ticks("b_hold_wait", 5, Z, Z);
    tick("b_hold_rise", ch(0, 0, 0, 1, 1, 0), Z);
    ticks("b_hold_high", 2, ch(0, 0, 0, 1, 0, 0), Z);
    raw_b = 1'b0;
    ticks("b_drop_wait", 5, ch(0, 0, 0, 1, 0, 0), Z);
    tick("b_drop", ch(0, 0, 0, 0, 0, 1), Z);

    // Reset with A high and a fall pending: outputs clear without a clock edge
    raw_a = 1'b1;
    ticks("pre_rst_wait", 5, Z, Z);
    tick("pre_rst_rise", ch(1, 1, 0, 0, 0, 0), Z);
    tick("pre_rst_high", ch(1, 0, 0, 0, 0, 0), Z);
    raw_a = 1'b0;
    ticks("pending_fall", 3, ch(1, 0, 0, 0, 0, 0), Z);
    raw_a = 1'b1;
    #1 rst = 1'b1;
    #1 check("async_rst", '0);
    ticks("in_rst", 2, Z, Z);
    rst = 1'b0;
    ticks("post_rst_wait", 5, Z, Z);
    tick("post_rst_rise", ch(1, 1, 0, 0, 0, 0), Z);
    tick("post_rst_high", ch(1, 0, 0, 0, 0, 0), Z);

    // DEBOUNCE_CYCLES=1: 3-edge latency, single synced-cycle glitch accepted
    raw_a1 = 1'b1;
    ticks("dc1_wait", 2, ch(1, 0, 0, 0, 0, 0), Z);
    tick("dc1_rise", ch(1, 0, 0, 0, 0, 0), ch(1, 1, 0, 0, 0, 0));
    tick("dc1_high", ch(1, 0, 0, 0, 0, 0), ch(1, 0, 0, 0, 0, 0));
    raw_a1 = 1'b0;
    tick("dc1_glitch_e1", ch(1, 0, 0, 0, 0, 0), ch(1, 0, 0, 0, 0, 0));
    raw_a1 = 1'b1;
    tick("dc1_glitch_e2", ch(1, 0, 0, 0, 0, 0), ch(1, 0, 0, 0, 0, 0));
    tick("dc1_glitch_fall", ch(1, 0, 0, 0, 0, 0), ch(0, 0, 1, 0, 0, 0));
    tick("dc1_glitch_rise", ch(1, 0, 0, 0, 0, 0), ch(1, 1, 0, 0, 0, 0));
    ticks("dc1_settle", 2, ch(1, 0, 0, 0, 0, 0), ch(1, 0, 0, 0, 0, 0));

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
